// File: rtl/dec_hazard_ctrl.sv
// Decode-stage issue controller: per-register in-flight write scoreboard,
// RAW/WAW issue gating and a fixed-length flush sequencer after redirects.
module dec_hazard_ctrl #(
  parameter int REG_NUM      = 32,
  parameter int ADDR_W       = 5,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              dec_valid,
  input  logic              dec_rs1_used,
  input  logic [ADDR_W-1:0] dec_rs1_addr,
  input  logic              dec_rs2_used,
  input  logic [ADDR_W-1:0] dec_rs2_addr,
  input  logic              dec_rd_wen,
  input  logic [ADDR_W-1:0] dec_rd_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd_addr,
  input  logic              redirect_req,
  output logic              issue_en,
  output logic              stall,
  output logic              flush,
  output logic              sb_busy,
  output logic              sb_err
);

  localparam logic [0:0]       ST_RUN   = 1'b0;
  localparam logic [0:0]       ST_FLUSH = 1'b1;
  localparam int               FCNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

  logic [CNT_W-1:0]  cnt_q [REG_NUM];
  logic [CNT_W-1:0]  cnt_d [REG_NUM];
  logic [0:0]        state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              flush_q, flush_d;
  logic              sb_busy_q, sb_busy_d;
  logic              sb_err_q, sb_err_d;

  logic [REG_NUM-1:0] inc_vec;
  logic [REG_NUM-1:0] dec_vec;
  logic [REG_NUM-1:0] err_vec;

  logic rs1_pend, rs2_pend, raw, waw;
  logic wb_hit_rd;

  // A writeback retiring the last in-flight write releases the reader in the same cycle.
  assign rs1_pend = (cnt_q[dec_rs1_addr] != '0) &
                    ~(wb_valid & (wb_rd_addr == dec_rs1_addr) & (cnt_q[dec_rs1_addr] == CNT_ONE));
  assign rs2_pend = (cnt_q[dec_rs2_addr] != '0) &
                    ~(wb_valid & (wb_rd_addr == dec_rs2_addr) & (cnt_q[dec_rs2_addr] == CNT_ONE));

  assign raw = (dec_rs1_used & (dec_rs1_addr != '0) & rs1_pend) |
               (dec_rs2_used & (dec_rs2_addr != '0) & rs2_pend);

  assign wb_hit_rd = wb_valid & (wb_rd_addr == dec_rd_addr);
  assign waw = dec_rd_wen & (dec_rd_addr != '0) & (cnt_q[dec_rd_addr] == CNT_MAX) & ~wb_hit_rd;

  assign issue_en = dec_valid & enable & ~raw & ~waw & (state_q == ST_RUN) & ~redirect_req;
  assign stall    = dec_valid & ~issue_en;

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign inc_vec[gi] = 1'b0;
        assign dec_vec[gi] = 1'b0;
        assign err_vec[gi] = 1'b0;
      end else begin : g_reg
        assign inc_vec[gi] = issue_en & dec_rd_wen & (dec_rd_addr == ADDR_W'(gi));
        assign dec_vec[gi] = wb_valid & (wb_rd_addr == ADDR_W'(gi));
        assign err_vec[gi] = dec_vec[gi] & (cnt_q[gi] == '0);
      end
    end
  endgenerate

  always_comb begin
    sb_busy_d = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] & ~dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_vec[i] & ~inc_vec[i] & (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      sb_busy_d = sb_busy_d | (cnt_d[i] != '0);
    end
    sb_err_d = sb_err_q | (|err_vec);
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flush_d = flush_q;
    case (state_q)
      ST_RUN: begin
        if (redirect_req) begin
          state_d = ST_FLUSH;
          flush_d = 1'b1;
          fcnt_d  = FCNT_RELOAD;
        end
      end
      default: begin
        // A redirect while flushing restarts the window instead of stacking.
        if (redirect_req) begin
          fcnt_d = FCNT_RELOAD;
        end else if (fcnt_q == '0) begin
          state_d = ST_RUN;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= '0;
      state_q   <= ST_RUN;
      fcnt_q    <= '0;
      flush_q   <= 1'b0;
      sb_busy_q <= 1'b0;
      sb_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      flush_q   <= flush_d;
      sb_busy_q <= sb_busy_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign flush   = flush_q;
  assign sb_busy = sb_busy_q;
  assign sb_err  = sb_err_q;

endmodule
